// File: rtl/decode_pkg.sv
// Shared types and constants for the 16-bit instruction decode queue.
// Holds field widths, read/write select encoding, opcode constants and the illegal-word rule.
package decode_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 3;
  localparam int REG_W   = 3;

  typedef enum logic [1:0] {
    NSEL_RN   = 2'b00,
    NSEL_RD   = 2'b01,
    NSEL_RM   = 2'b10,
    NSEL_NONE = 2'b11
  } nsel_t;

  localparam logic [OPC_W-1:0] OPC_MOV  = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
  localparam logic [OPC_W-1:0] OPC_LDR  = 3'b011;
  localparam logic [OPC_W-1:0] OPC_STR  = 3'b100;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

  // Encodings with no defined meaning: opcode 000, MOV with op[0] set, LDR/STR with a non-zero op.
  function automatic logic is_illegal(input logic [INSTR_W-1:0] instr);
    logic [OPC_W-1:0] opc;
    logic [1:0]       op;
    opc = instr[15:13];
    op  = instr[12:11];
    case (opc)
      3'b000:           is_illegal = 1'b1;
      OPC_MOV:          is_illegal = op[0];
      OPC_LDR, OPC_STR: is_illegal = (op != 2'b00);
      default:          is_illegal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_queue_if.sv
// Fetch-side and consumer-side signals of the decode queue, bundled with master/slave views.
// Optional DECODE_ILLEGAL_CHK_EN adds out_illegal and illegal_sticky.
interface instr_decode_queue_if #(
  parameter int DATA_W = 16,
  parameter int NRD    = 2
);
  import decode_pkg::*;

  logic                   flush;
  logic [INSTR_W-1:0]     in_instr;
  logic                   in_valid;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [OPC_W-1:0]       opcode;
  logic [1:0]             op;
  logic [1:0]             alu_op;
  logic [1:0]             shift;
  logic [DATA_W-1:0]      sximm5;
  logic [DATA_W-1:0]      sximm8;
  logic [2*NRD-1:0]       nsel;
  logic [REG_W*NRD-1:0]   readnum;
  logic [1:0]             wsel;
  logic [REG_W-1:0]       writenum;
`ifdef DECODE_ILLEGAL_CHK_EN
  logic                   out_illegal;
  logic                   illegal_sticky;
`endif

  modport master (
    output flush, in_instr, in_valid, out_ready, nsel, wsel,
`ifdef DECODE_ILLEGAL_CHK_EN
    input  out_illegal, illegal_sticky,
`endif
    input  in_ready, out_valid, opcode, op, alu_op, shift, sximm5, sximm8, readnum, writenum
  );

  modport slave (
    input  flush, in_instr, in_valid, out_ready, nsel, wsel,
`ifdef DECODE_ILLEGAL_CHK_EN
    output out_illegal, illegal_sticky,
`endif
    output in_ready, out_valid, opcode, op, alu_op, shift, sximm5, sximm8, readnum, writenum
  );

endinterface

// File: rtl/instr_field_mux.sv
// Picks one 3-bit register number out of an instruction word: Rn, Rd, Rm or zero.
module instr_field_mux
  import decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  nsel_t              sel,
  output logic [REG_W-1:0]   regnum
);

  logic unused_bits;
  assign unused_bits = ^{instr[15:11], instr[4:3]};

  // NOTE: assigning a default before the case keeps this block purely combinational; without it a missed branch infers a latch.
  always_comb begin
    regnum = '0;
    case (sel)
      NSEL_RN: regnum = instr[10:8];
      NSEL_RD: regnum = instr[7:5];
      NSEL_RM: regnum = instr[2:0];
      default: regnum = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode_queue.sv
// DEPTH-entry instruction FIFO with valid/ready on both sides; the head entry is decoded combinationally.
// Define DECODE_ILLEGAL_CHK_EN to add illegal-word flagging (out_illegal, illegal_sticky).
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  parameter int NRD    = 2
) (
  input logic               clk,
  input logic               rst_n,
  instr_decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Handshakes look only at stored state, so a pop never opens in_ready in the same cycle.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  assign push = bus.in_valid && !full && !bus.flush;
  assign pop  = bus.out_ready && !empty && !bus.flush;

  // NOTE: the storage array is deliberately not reset; count and pointers alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_instr;
  end

  // NOTE: all sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Zeroing the head word when empty forces every decoded field, including register selects, to 0.
  assign head = empty ? '0 : mem[rd_ptr];

  assign bus.opcode = head[15:13];
  assign bus.op     = head[12:11];
  assign bus.alu_op = head[12:11];
  assign bus.shift  = head[4:3];
  assign bus.sximm5 = {{(DATA_W-5){head[4]}}, head[4:0]};
  assign bus.sximm8 = {{(DATA_W-8){head[7]}}, head[7:0]};

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    instr_field_mux u_rd_mux (
      .instr  (head),
      .sel    (nsel_t'(bus.nsel[2*i +: 2])),
      .regnum (bus.readnum[REG_W*i +: REG_W])
    );
  end

  instr_field_mux u_wr_mux (
    .instr  (head),
    .sel    (nsel_t'(bus.wsel)),
    .regnum (bus.writenum)
  );

`ifdef DECODE_ILLEGAL_CHK_EN
  logic head_illegal;
  logic sticky_q;

  assign head_illegal    = !empty && is_illegal(head);
  assign bus.out_illegal = head_illegal;
  assign bus.illegal_sticky = sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   sticky_q <= 1'b0;
    else if (bus.flush)           sticky_q <= 1'b0;
    else if (pop && head_illegal) sticky_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: decode vectors, queue corner sequences and a randomized run against a queue model.
module tb_instr_decode_queue;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_decode_queue_if #(.DATA_W(16), .NRD(2)) bus ();
  instr_decode_queue_if #(.DATA_W(32), .NRD(1)) bus32 ();

  instr_decode_queue #(.DATA_W(16), .DEPTH(2), .NRD(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  instr_decode_queue #(.DATA_W(32), .DEPTH(4), .NRD(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0; bus.in_instr = '0; bus.nsel = '0; bus.wsel = '0;
    bus32.flush = 0; bus32.in_valid = 0; bus32.out_ready = 0; bus32.in_instr = '0; bus32.nsel = '0; bus32.wsel = '0;
  endtask

  // Reference decode helpers, straight from the field definitions.
  function automatic logic [2:0] fld(input logic [15:0] w, input logic [1:0] s);
    case (s)
      2'd0:    return w[10:8];
      2'd1:    return w[7:5];
      2'd2:    return w[2:0];
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [15:0] sx(input logic [15:0] w, input int bits);
    int v;
    v = int'(w) & ((1 << bits) - 1);
    if (v >= (1 << (bits - 1))) v -= (1 << bits);
    return 16'(v);
  endfunction

  function automatic bit ill(input logic [15:0] w);
    int opc, op;
    opc = int'(w[15:13]);
    op  = int'(w[12:11]);
    if (opc == 0) return 1;
    if (opc == 6 && (op == 1 || op == 3)) return 1;
    if ((opc == 3 || opc == 4) && op != 0) return 1;
    return 0;
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  nsel;
    logic [1:0]  wsel;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  shift;
    logic [15:0] sx5;
    logic [15:0] sx8;
    logic [5:0]  readnum;
    logic [2:0]  writenum;
    logic        illegal;
  } vec_t;

  vec_t vecs [5];

  logic [15:0] q [$];
  bit          sticky_m;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'hD107, 4'b0000, 2'b00, 3'b110, 2'b10, 2'b00, 16'h0007, 16'h0007, {3'd1, 3'd1}, 3'd1, 1'b0};
    vecs[1] = '{16'hA2A3, 4'b1000, 2'b01, 3'b101, 2'b00, 2'b00, 16'h0003, 16'hFFA3, {3'd3, 3'd2}, 3'd5, 1'b0};
    vecs[2] = '{16'hD1F0, 4'b0111, 2'b10, 3'b110, 2'b10, 2'b10, 16'hFFF0, 16'hFFF0, {3'd7, 3'd0}, 3'd0, 1'b0};
    vecs[3] = '{16'h6C95, 4'b0010, 2'b11, 3'b011, 2'b01, 2'b10, 16'hFFF5, 16'hFF95, {3'd4, 3'd5}, 3'd0, 1'b1};
    vecs[4] = '{16'hBF7F, 4'b1101, 2'b00, 3'b101, 2'b11, 2'b11, 16'hFFFF, 16'h007F, {3'd0, 3'd3}, 3'd7, 1'b0};

    idle();
    rst_n = 1'b0;
    #12;
    check("reset out_valid", bus.out_valid, 0);
    check("reset in_ready", bus.in_ready, 1);
    check("reset sximm8", bus.sximm8, 0);
    check("reset32 out_valid", bus32.out_valid, 0);
    rst_n = 1'b1;
    tick();

    // Decode table: push one word, check it at the head, pop it.
    for (int i = 0; i < 5; i++) begin
      bus.in_instr = vecs[i].instr; bus.nsel = vecs[i].nsel; bus.wsel = vecs[i].wsel;
      bus.in_valid = 1;
      #1;
      check("no bypass out_valid", bus.out_valid, 0);
      tick();
      bus.in_valid = 0;
      #1;
      check("vec out_valid", bus.out_valid, 1);
      check("vec opcode", bus.opcode, vecs[i].opcode);
      check("vec op", bus.op, vecs[i].op);
      check("vec alu_op", bus.alu_op, vecs[i].op);
      check("vec shift", bus.shift, vecs[i].shift);
      check("vec sximm5", bus.sximm5, vecs[i].sx5);
      check("vec sximm8", bus.sximm8, vecs[i].sx8);
      check("vec readnum", bus.readnum, vecs[i].readnum);
      check("vec writenum", bus.writenum, vecs[i].writenum);
`ifdef DECODE_ILLEGAL_CHK_EN
      check("vec out_illegal", bus.out_illegal, vecs[i].illegal);
`endif
      bus.out_ready = 1;
      tick();
      bus.out_ready = 0;
      #1;
      check("vec popped out_valid", bus.out_valid, 0);
    end

    // Full queue: third word refused; a pop at full does not admit a push.
    bus.nsel = '0; bus.wsel = '0;
    bus.in_valid = 1;
    bus.in_instr = 16'hE011; tick();
    #1; check("fill1 in_ready", bus.in_ready, 1);
    bus.in_instr = 16'hE022; tick();
    #1; check("fill2 in_ready", bus.in_ready, 0);
    bus.in_instr = 16'hE033; tick();
    #1; check("full head", bus.sximm8, 16'h0011);
    bus.in_instr = 16'hE044; bus.out_ready = 1; tick();
    #1;
    check("pop at full head", bus.sximm8, 16'h0022);
    check("pop at full in_ready", bus.in_ready, 1);
    bus.in_instr = 16'hE055; tick();
    #1;
    check("push+pop head", bus.sximm8, 16'h0055);
    check("push+pop in_ready", bus.in_ready, 1);
    bus.in_instr = 16'hE066; bus.out_ready = 0; tick();
    #1;
    check("refill in_ready", bus.in_ready, 0);
    bus.in_valid = 0; bus.out_ready = 1; tick();
    #1; check("drain order", bus.sximm8, 16'h0066);
    tick();
    #1; check("drained out_valid", bus.out_valid, 0);
    bus.out_ready = 0;

    // Flush beats a same-cycle push; decoded outputs go to zero.
    bus.in_valid = 1;
    bus.in_instr = 16'hD1F0; tick();
    bus.in_instr = 16'hA2A3; tick();
    bus.flush = 1; bus.in_instr = 16'hBF7F; tick();
    bus.flush = 0; bus.in_valid = 0; bus.nsel = 4'b0110; bus.wsel = 2'b01;
    #1;
    check("flush out_valid", bus.out_valid, 0);
    check("flush in_ready", bus.in_ready, 1);
    check("flush opcode", bus.opcode, 0);
    check("flush op", bus.op, 0);
    check("flush shift", bus.shift, 0);
    check("flush sximm5", bus.sximm5, 0);
    check("flush sximm8", bus.sximm8, 0);
    check("flush readnum", bus.readnum, 0);
    check("flush writenum", bus.writenum, 0);

    // Async reset in the middle of traffic.
    bus.in_valid = 1; bus.in_instr = 16'hD107; tick();
    tick();
    bus.in_valid = 0;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", bus.out_valid, 0);
    check("midreset in_ready", bus.in_ready, 1);
    check("midreset readnum", bus.readnum, 0);
    #4;
    rst_n = 1'b1;
    tick();
    #1; check("postreset out_valid", bus.out_valid, 0);

    // Wide immediates and DEPTH=4 on the second instance.
    begin
      logic [15:0] w32 [4];
      logic [31:0] e8  [4];
      w32[0] = 16'hD1F0; w32[1] = 16'h1234; w32[2] = 16'h5678; w32[3] = 16'h9ABC;
      e8[0] = 32'hFFFFFFF0; e8[1] = 32'h00000034; e8[2] = 32'h00000078; e8[3] = 32'hFFFFFFBC;
      bus32.in_valid = 1;
      for (int i = 0; i < 4; i++) begin
        bus32.in_instr = w32[i];
        tick();
        #1; check("w32 in_ready", bus32.in_ready, (i < 3) ? 1 : 0);
      end
      bus32.in_instr = 16'h0055; tick();
      bus32.in_valid = 0;
      #1;
      check("w32 sximm5", bus32.sximm5, 32'hFFFFFFF0);
      check("w32 readnum", bus32.readnum, 3'd1);
      bus32.out_ready = 1;
      for (int i = 0; i < 4; i++) begin
        check("w32 sximm8", bus32.sximm8, e8[i]);
        tick();
        #1;
      end
      check("w32 drained", bus32.out_valid, 0);
      bus32.out_ready = 0;
    end

`ifdef DECODE_ILLEGAL_CHK_EN
    bus.flush = 1; tick(); bus.flush = 0;
    bus.in_valid = 1; bus.in_instr = 16'h0000; tick();
    bus.in_valid = 0;
    #1;
    check("ill out_illegal", bus.out_illegal, 1);
    check("ill sticky before pop", bus.illegal_sticky, 0);
    bus.out_ready = 1; tick(); bus.out_ready = 0;
    #1;
    check("ill sticky after pop", bus.illegal_sticky, 1);
    check("ill out_illegal empty", bus.out_illegal, 0);
    bus.flush = 1; tick(); bus.flush = 0;
    #1; check("ill sticky flushed", bus.illegal_sticky, 0);
    bus.in_valid = 1; bus.in_instr = 16'hD800; tick();
    bus.in_valid = 0; bus.out_ready = 1; bus.flush = 1; tick();
    bus.out_ready = 0; bus.flush = 0;
    #1; check("ill flush beats set", bus.illegal_sticky, 0);
`endif

    // Randomized run against a plain queue model.
    bus.flush = 1; tick(); bus.flush = 0;
    q.delete();
    sticky_m = 0;
    for (int n = 0; n < 600; n++) begin
      logic [15:0] h;
      bit          v;
      bit          pu, po;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      bus.in_instr  = 16'($urandom);
      bus.nsel      = 4'($urandom);
      bus.wsel      = 2'($urandom);
      #1;
      v = (q.size() > 0);
      h = v ? q[0] : 16'h0;
      check("rnd out_valid", bus.out_valid, v);
      check("rnd in_ready", bus.in_ready, q.size() < DEPTH);
      check("rnd opcode", bus.opcode, v ? h[15:13] : 3'd0);
      check("rnd op", bus.op, v ? h[12:11] : 2'd0);
      check("rnd alu_op", bus.alu_op, v ? h[12:11] : 2'd0);
      check("rnd shift", bus.shift, v ? h[4:3] : 2'd0);
      check("rnd sximm5", bus.sximm5, v ? sx(h, 5) : 16'd0);
      check("rnd sximm8", bus.sximm8, v ? sx(h, 8) : 16'd0);
      check("rnd readnum0", bus.readnum[2:0], v ? fld(h, bus.nsel[1:0]) : 3'd0);
      check("rnd readnum1", bus.readnum[5:3], v ? fld(h, bus.nsel[3:2]) : 3'd0);
      check("rnd writenum", bus.writenum, v ? fld(h, bus.wsel) : 3'd0);
`ifdef DECODE_ILLEGAL_CHK_EN
      check("rnd out_illegal", bus.out_illegal, v && ill(h));
      check("rnd sticky", bus.illegal_sticky, sticky_m);
`endif
      pu = bus.in_valid && (q.size() < DEPTH);
      po = bus.out_ready && v;
      if (bus.flush) begin
        q.delete();
        sticky_m = 0;
      end else begin
        if (po) begin
          if (ill(q[0])) sticky_m = 1;
          void'(q.pop_front());
        end
        if (pu) q.push_back(bus.in_instr);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
